// File: rtl/calculator_pkg.sv
// Shared types and defaults for the streaming calculator controller.
// Holds the width defaults, the controller state enum and the lane-count helper.
package calculator_pkg;

    localparam int DEF_ADDR_W        = 10;
    localparam int DEF_DATA_W        = 32;
    localparam int DEF_MEM_WORD_SIZE = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_LOAD,
        S_EXEC,
        S_WRITE,
        S_DONE
    } ctrl_state_t;

    function automatic int res_per_word(input int mem_w, input int data_w);
        return mem_w / data_w;
    endfunction

endpackage

// File: rtl/result_packer.sv
// Result buffer: RES_PER_WORD lanes of DATA_W, filled one lane per capture.
// full_o flags that the current capture fills the last lane.
module result_packer #(
    parameter int DATA_W       = 32,
    parameter int RES_PER_WORD = 2,
    parameter int LANE_W       = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [LANE_W-1:0]              lane_cnt,
    input  logic                           cap_en,
    input  logic                           clear,
    input  logic [DATA_W-1:0]              result_i,
    output logic [RES_PER_WORD*DATA_W-1:0] word_o,
    output logic                           full_o
);

    logic [RES_PER_WORD-1:0][DATA_W-1:0] lanes_q;

    // Lane storage: cleared on reset or flush, one lane written per capture.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lanes_q <= '0;
        end else if (clear) begin
            lanes_q <= '0;
        end else if (cap_en) begin
            lanes_q[lane_cnt] <= result_i;
        end
    end

    assign word_o = lanes_q;
    assign full_o = cap_en && (lane_cnt == LANE_W'(RES_PER_WORD - 1));

endmodule

// File: rtl/calc_stream_ctrl.sv
// Streams operand words from SRAM through an external adder and packs
// results into write-back words; start/busy/done handshake to the top level.
module calc_stream_ctrl
    import calculator_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int MEM_WORD_SIZE = DEF_MEM_WORD_SIZE
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     sub_i,
    input  logic [ADDR_W-1:0]        read_start_addr,
    input  logic [ADDR_W-1:0]        read_end_addr,
    input  logic [ADDR_W-1:0]        write_start_addr,
    input  logic [ADDR_W-1:0]        write_end_addr,
    output logic                     read,
    output logic [ADDR_W-1:0]        r_addr,
    input  logic [MEM_WORD_SIZE-1:0] r_data,
    output logic                     write,
    output logic [ADDR_W-1:0]        w_addr,
    output logic [MEM_WORD_SIZE-1:0] w_data,
    output logic [DATA_W-1:0]        op_a,
    output logic [DATA_W-1:0]        op_b,
    output logic                     sub_o,
    input  logic [DATA_W-1:0]        result_i,
    input  logic                     carry_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     ovf_o
);

    localparam int RES_PER_WORD = res_per_word(MEM_WORD_SIZE, DATA_W);
    localparam int LANE_W = (RES_PER_WORD > 1) ? $clog2(RES_PER_WORD) : 1;

    if (MEM_WORD_SIZE != 2 * DATA_W) begin : g_width_chk
        $error("MEM_WORD_SIZE must equal 2*DATA_W");
    end

    ctrl_state_t state_q, state_d;

    logic [ADDR_W-1:0] raddr_q, rend_q;
    logic [ADDR_W-1:0] waddr_q, wend_q;
    logic [LANE_W-1:0] lane_q;
    logic              rd_last_q;
    logic              cap_en, clr, full;
    logic              bad_range;

    assign bad_range = (read_end_addr < read_start_addr) ||
                       (write_end_addr < write_start_addr);

    result_packer #(
        .DATA_W       (DATA_W),
        .RES_PER_WORD (RES_PER_WORD),
        .LANE_W       (LANE_W)
    ) u_packer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .lane_cnt (lane_q),
        .cap_en   (cap_en),
        .clear    (clr),
        .result_i (result_i),
        .word_o   (w_data),
        .full_o   (full)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_d = state_q;
        read    = 1'b0;
        write   = 1'b0;
        cap_en  = 1'b0;
        clr     = 1'b0;
        done_o  = 1'b0;
        busy_o  = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = bad_range ? S_DONE : S_READ;
            end
            S_READ: begin
                read    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT:  state_d = S_LOAD;
            S_LOAD:  state_d = S_EXEC;
            S_EXEC: begin
                cap_en  = 1'b1;
                state_d = (full || raddr_q == rend_q) ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                write = 1'b1;
                clr   = 1'b1;
                if (rd_last_q || waddr_q == wend_q) state_d = S_DONE;
                else                                state_d = S_READ;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Run configuration, address counters, operands and status flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            raddr_q   <= '0;
            rend_q    <= '0;
            waddr_q   <= '0;
            wend_q    <= '0;
            lane_q    <= '0;
            rd_last_q <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            sub_o     <= 1'b0;
            err_o     <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        raddr_q   <= read_start_addr;
                        rend_q    <= read_end_addr;
                        waddr_q   <= write_start_addr;
                        wend_q    <= write_end_addr;
                        lane_q    <= '0;
                        rd_last_q <= 1'b0;
                        sub_o     <= sub_i;
                        err_o     <= bad_range;
                        ovf_o     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    op_a <= r_data[DATA_W-1:0];
                    op_b <= r_data[MEM_WORD_SIZE-1:DATA_W];
                end
                S_EXEC: begin
                    ovf_o     <= ovf_o | carry_i;
                    raddr_q   <= raddr_q + 1'b1;
                    rd_last_q <= (raddr_q == rend_q);
                    lane_q    <= lane_q + 1'b1;
                end
                S_WRITE: begin
                    lane_q  <= '0;
                    waddr_q <= waddr_q + 1'b1;
                    if (!rd_last_q && waddr_q == wend_q) err_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign r_addr = raddr_q;
    assign w_addr = waddr_q;

endmodule
